lut_layer_sched: RTL and testbench
==================================

# lut_layer_sched

Time-multiplexed evaluator for one LogicNet layer of 6-bit-address / 2-bit-output neuron truth tables. All neurons share one truth-table memory, so one evaluation slot serves every neuron in turn. The block accepts a pre-gathered address vector, evaluates neurons 0..NEURONS-1 one per cycle, and presents the assembled output vector to the next layer over a valid/ready handshake. Truth tables are loaded at run time through a config write port. The block sits between generated fan-in wiring and the next layer, or an ensemble voter.

## Interface
- NEURONS, 8: neurons in the layer; must be ≥2.
- ADDR_W, 6: LUT address width per neuron (3 inputs × 2 bits).
- DATA_W, 2: LUT output width per neuron.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_we  in  1  truth-table write strobe.
- cfg_neuron  in  $clog2(NEURONS)  target neuron.
- cfg_addr  in  ADDR_W  table entry.
- cfg_data  in  DATA_W  entry value.
- cfg_ready  out  1  high when a write will be accepted (IDLE).
- s_valid  in  1  input vector valid.
- s_ready  out  1  block can accept an input vector.
- s_data  in  NEURONS*ADDR_W  neuron k address = s_data[k*ADDR_W +: ADDR_W].
- m_valid  out  1  result vector valid.
- m_ready  in  1  downstream accepts the result.
- m_data  out  NEURONS*DATA_W  neuron k result = m_data[k*DATA_W +: DATA_W].
- busy  out  1  high in EVAL or DRAIN.

## Operation
- FSM states: IDLE, EVAL, DRAIN, DONE.
- IDLE:
  - s_ready=1, cfg_ready=1.
  - On s_valid: capture s_data into the internal address register, clear m_data to 0, clear neuron counter k, go to EVAL.
- EVAL:
  - Each cycle, issue a read of table word {k, addr_k} to the memory, then k++.
  - After issuing k=NEURONS-1, go to DRAIN.
- DRAIN: one cycle, so the last read returns.
- Read data for neuron j is written into m_data slice j on the cycle after its address is issued. This applies in both EVAL and DRAIN.
- DONE:
  - m_valid=1; m_data is held stable.
  - On m_ready, go to IDLE.
- Config writes:
  - A write occurs when cfg_we && cfg_ready. The word is readable from the next cycle.
  - cfg_we outside IDLE is ignored and the write is lost. The master must gate writes on cfg_ready.
- cfg_we and s_valid together in IDLE: both are accepted. The write completes before the first EVAL read, so the evaluation sees the new value.
- s_data may change freely after acceptance; the captured copy is used.
- Memory contents are not affected by rst. Tables survive reset.

## Timing
- Reset values:
  - State is IDLE; m_valid=0, m_data=0, busy=0, k=0.
  - s_ready and cfg_ready are 0 while rst=1, and 1 from the first cycle after rst is deasserted.
- Cycle numbering: accept occurs in cycle T (s_valid && s_ready).
  - Neuron j address is issued in cycle T+1+j.
  - Neuron j data is captured at the end of cycle T+2+j.
  - DRAIN is cycle T+NEURONS+1.
  - m_valid rises in cycle T+NEURONS+2.
- Latency from accept to m_valid is NEURONS+2 cycles.
- Minimum initiation interval is NEURONS+3 cycles: when m_ready is already high, s_ready returns in cycle T+NEURONS+3.
- m_valid stays high, with m_data unchanged, until the cycle in which m_ready=1. It drops on the next cycle.
- s_ready and cfg_ready are low from T+1 until IDLE is re-entered. No input is accepted while DONE is stalled.
- rst in any state returns the FSM to IDLE on the next edge. A partial result is discarded, and m_valid never pulses for an aborted vector.
- Counter k is $clog2(NEURONS) bits. The EVAL→DRAIN exit compares against NEURONS-1, so non-power-of-two NEURONS never wraps.

## Structure
- Package logicnet_pkg holds:
  - constants LUT_ADDR_W=6 and LUT_DATA_W=2 (the parameter defaults);
  - typedef sched_state_t for {IDLE, EVAL, DRAIN, DONE}.
- Sub-module lut_tt_ram:
  - NEURONS*2^ADDR_W words × DATA_W;
  - one synchronous write port, one synchronous read port with 1-cycle latency;
  - word index = {neuron, addr};
  - no reset; distributed-ROM/RAM inference style.
- Top level contains the FSM, counter k, the capture register and the output register.

## Test plan
- Load table:
  - neuron 0 entries: all 2'b11, except 6'b111111=2'b00 and 6'b001110=2'b01;
  - neurons 1..7: entry = addr[1:0].
  - Send s_data with neuron 0 address 6'b111111 and neuron k address 6'b000000+k.
  - Required: m_valid at T+10; m_data[1:0]=2'b00; slice k = k[1:0].
- Backpressure: hold m_ready=0 for 20 cycles after m_valid.
  - Required: m_data stays constant; s_ready=0 throughout.
  - Raise m_ready; m_valid drops next cycle and s_ready rises.
- Back-to-back vectors with m_ready tied high:
  - Required: accepts 11 cycles apart; each result matches the golden model.
- Config during EVAL:
  - cfg_we to neuron 0, addr 6'b111111, data 2'b11 while busy.
  - Required: write dropped; a re-run still gives 2'b00.
- Simultaneous cfg_we and s_valid in IDLE:
  - Write neuron 2, entry 6'b000010 = 2'b01; vector addresses neuron 2 at 6'b000010.
  - Required: m_data[5:4]=2'b01.
- rst asserted at T+4 mid-EVAL:
  - Required: next cycle state IDLE, m_valid=0, m_data=0.
  - Tables retained: a re-run produces the same results as scenario 1.

Source files
------------

// File: rtl/logicnet_pkg.sv
// Shared constants and types for the LogicNet layer scheduler.
// LUT_ADDR_W / LUT_DATA_W are the default per-neuron truth-table shape.
package logicnet_pkg;

    localparam int unsigned LUT_ADDR_W = 6;
    localparam int unsigned LUT_DATA_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/lut_layer_sched_if.sv
// Config, input-vector and result-vector handshakes of lut_layer_sched.
// The slave modport is the scheduler side; master is the surrounding fabric.
interface lut_layer_sched_if
    import logicnet_pkg::*;
#(
    parameter int unsigned NEURONS = 8,
    parameter int unsigned ADDR_W  = LUT_ADDR_W,
    parameter int unsigned DATA_W  = LUT_DATA_W
);

    logic                        cfg_we;
    logic [$clog2(NEURONS)-1:0]  cfg_neuron;
    logic [ADDR_W-1:0]           cfg_addr;
    logic [DATA_W-1:0]           cfg_data;
    logic                        cfg_ready;

    logic                        s_valid;
    logic                        s_ready;
    logic [NEURONS*ADDR_W-1:0]   s_data;

    logic                        m_valid;
    logic                        m_ready;
    logic [NEURONS*DATA_W-1:0]   m_data;

    logic                        busy;

    modport master (
        output cfg_we, cfg_neuron, cfg_addr, cfg_data,
        input  cfg_ready,
        output s_valid, s_data,
        input  s_ready,
        input  m_valid, m_data,
        output m_ready,
        input  busy
    );

    modport slave (
        input  cfg_we, cfg_neuron, cfg_addr, cfg_data,
        output cfg_ready,
        input  s_valid, s_data,
        output s_ready,
        output m_valid, m_data,
        input  m_ready,
        output busy
    );

endinterface

// File: rtl/lut_tt_ram.sv
// Shared truth-table store: one word per {neuron, addr}, 1-cycle synchronous read.
// Deliberately not reset so loaded tables survive a scheduler reset.
module lut_tt_ram #(
    parameter int unsigned NEURONS = 8,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 2
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [$clog2(NEURONS)+ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]                   wdata,
    input  logic [$clog2(NEURONS)+ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]                   rdata
);

    localparam int unsigned DEPTH = NEURONS * (2 ** ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lut_layer_sched.sv
// Time-multiplexed evaluator for one LogicNet layer: one shared truth-table
// read per cycle, neuron results assembled into a vector for the next layer.
module lut_layer_sched
    import logicnet_pkg::*;
#(
    parameter int unsigned NEURONS = 8,
    parameter int unsigned ADDR_W  = LUT_ADDR_W,
    parameter int unsigned DATA_W  = LUT_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    lut_layer_sched_if.slave bus
);

    localparam int unsigned   NW     = $clog2(NEURONS);
    localparam int unsigned   IW     = NW + ADDR_W;
    localparam logic [NW-1:0] K_LAST = NW'(NEURONS - 1);

    sched_state_t              state_q, state_d;
    logic [NW-1:0]             k_q, k_d;
    logic [NEURONS*ADDR_W-1:0] addr_q, addr_d;
    logic [NEURONS*DATA_W-1:0] m_data_q, m_data_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [NW-1:0]             rd_idx_q, rd_idx_d;

    logic              idle_ok;
    logic              ram_we;
    logic [ADDR_W-1:0] addr_k;
    logic [IW-1:0]     raddr;
    logic [IW-1:0]     waddr;
    logic [DATA_W-1:0] rdata;

    // Handshakes are withheld while rst is high, even though the state is already IDLE.
    assign idle_ok = (state_q == IDLE) && !rst;
    assign ram_we  = bus.cfg_we && idle_ok;
    assign addr_k  = addr_q[int'(k_q)*ADDR_W +: ADDR_W];
    assign raddr   = {k_q, addr_k};
    assign waddr   = {bus.cfg_neuron, bus.cfg_addr};

    lut_tt_ram #(
        .NEURONS (NEURONS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (waddr),
        .wdata (bus.cfg_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        addr_d     = addr_q;
        m_data_d   = m_data_q;
        rd_valid_d = 1'b0;
        rd_idx_d   = k_q;

        // Read issued last cycle lands in its neuron slice (EVAL and DRAIN).
        if (rd_valid_q) begin
            m_data_d[int'(rd_idx_q)*DATA_W +: DATA_W] = rdata;
        end

        case (state_q)
            IDLE: begin
                if (bus.s_valid && idle_ok) begin
                    addr_d   = bus.s_data;
                    m_data_d = '0;
                    k_d      = '0;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                rd_valid_d = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                if (bus.m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            addr_q     <= '0;
            m_data_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            addr_q     <= addr_d;
            m_data_q   <= m_data_d;
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    assign bus.s_ready   = idle_ok;
    assign bus.cfg_ready = idle_ok;
    assign bus.m_valid   = (state_q == DONE);
    assign bus.m_data    = m_data_q;
    assign bus.busy      = (state_q == EVAL) || (state_q == DRAIN);

endmodule

// File: tb/tb_lut_layer_sched.sv
// Directed bench for lut_layer_sched: table-driven vectors plus hand-written
// backpressure, config-while-busy, mid-EVAL reset and simultaneous-write sequences.
module tb_lut_layer_sched;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    lut_layer_sched_if #(.NEURONS(N), .ADDR_W(6), .DATA_W(2)) bus ();

    lut_layer_sched #(
        .NEURONS (N),
        .ADDR_W  (6),
        .DATA_W  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [47:0] sd;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_mvalid(output int lat, output logic [15:0] md);
        lat = 0;
        md  = '0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.m_valid) begin
                lat = c;
                md  = bus.m_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge where m_valid was first seen.
    task automatic run_vec(input logic [47:0] sd, output int lat, output logic [15:0] md,
                           output int acc);
        int w = 0;
        while (!bus.s_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.s_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
        bus.s_valid = 1'b1;
        bus.s_data  = sd;
        acc         = cyc;
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = ~sd;
        wait_mvalid(lat, md);
    endtask

    initial begin
        int          lat;
        int          acc;
        int          prev_acc;
        logic [15:0] md;
        logic [1:0]  d;
        logic        ok_valid, ok_data, ok_sready;

        vecs[0] = '{"v0_plan",   {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd63}, 16'hE4E4};
        vecs[1] = '{"v1_n0_14",  {{7{6'd0}}, 6'd14},                               16'h0001};
        vecs[2] = '{"v2_all_11", {{7{6'd63}}, 6'd0},                               16'hFFFF};
        vecs[3] = '{"v3_mixed",  {{7{6'd2}}, 6'd1},                                16'hAAAB};

        rst            = 1'b1;
        bus.cfg_we     = 1'b0;
        bus.cfg_neuron = '0;
        bus.cfg_addr   = '0;
        bus.cfg_data   = '0;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.m_ready    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_cfg_ready", bus.cfg_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", bus.s_ready, 1);
        check("post_rst_cfg_ready", bus.cfg_ready, 1);

        // Load tables from the test plan.
        for (int n = 0; n < N; n++) begin
            for (int a = 0; a < 64; a++) begin
                if (n == 0) d = (a == 63) ? 2'b00 : (a == 14) ? 2'b01 : 2'b11;
                else        d = 2'(a);
                bus.cfg_we     = 1'b1;
                bus.cfg_neuron = 3'(n);
                bus.cfg_addr   = 6'(a);
                bus.cfg_data   = d;
                @(negedge clk);
            end
        end
        bus.cfg_we = 1'b0;

        // Back-to-back table vectors with m_ready tied high.
        bus.m_ready = 1'b1;
        prev_acc    = 0;
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i].sd, lat, md, acc);
            check({vecs[i].name, "_latency"}, lat, 10);
            check({vecs[i].name, "_data"}, md, vecs[i].exp);
            if (i > 0) check({vecs[i].name, "_interval"}, acc - prev_acc, 11);
            prev_acc = acc;
        end

        // Backpressure: hold DONE for 20 cycles.
        @(negedge clk);
        bus.m_ready = 1'b0;
        run_vec(vecs[0].sd, lat, md, acc);
        check("bp_latency", lat, 10);
        check("bp_data", md, 16'hE4E4);
        ok_valid  = 1'b1;
        ok_data   = 1'b1;
        ok_sready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            ok_valid  &= bus.m_valid;
            ok_data   &= (bus.m_data == 16'hE4E4);
            ok_sready &= !bus.s_ready;
        end
        check("bp_m_valid_held", ok_valid, 1);
        check("bp_m_data_stable", ok_data, 1);
        check("bp_s_ready_low", ok_sready, 1);
        bus.m_ready = 1'b1;
        @(negedge clk);
        check("bp_release_m_valid", bus.m_valid, 0);
        check("bp_release_s_ready", bus.s_ready, 1);

        // Config write while busy must be dropped.
        bus.s_valid = 1'b1;
        bus.s_data  = vecs[0].sd;
        @(negedge clk);
        bus.s_valid    = 1'b0;
        bus.cfg_we     = 1'b1;
        bus.cfg_neuron = 3'd0;
        bus.cfg_addr   = 6'd63;
        bus.cfg_data   = 2'b11;
        check("cfgeval_busy", bus.busy, 1);
        check("cfgeval_cfg_ready", bus.cfg_ready, 0);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        wait_mvalid(lat, md);
        check("cfgeval_latency", lat, 9);
        check("cfgeval_data", md, 16'hE4E4);
        @(negedge clk);
        run_vec(vecs[0].sd, lat, md, acc);
        check("cfgeval_rerun_slice0", md[1:0], 2'b00);
        check("cfgeval_rerun_data", md, 16'hE4E4);

        // Reset in cycle T+4 of an evaluation.
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = vecs[0].sd;
        @(negedge clk);
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy_before", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_m_valid", bus.m_valid, 0);
        check("midrst_m_data", bus.m_data, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_s_ready_in_rst", bus.s_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_s_ready_after", bus.s_ready, 1);
        ok_valid = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            ok_valid &= !bus.m_valid;
        end
        check("midrst_no_m_valid", ok_valid, 1);
        run_vec(vecs[0].sd, lat, md, acc);
        check("midrst_rerun_latency", lat, 10);
        check("midrst_rerun_data", md, 16'hE4E4);

        // Simultaneous config write and vector accept in IDLE.
        @(negedge clk);
        bus.cfg_we     = 1'b1;
        bus.cfg_neuron = 3'd2;
        bus.cfg_addr   = 6'd2;
        bus.cfg_data   = 2'b01;
        bus.s_valid    = 1'b1;
        bus.s_data     = {{7{6'd2}}, 6'd1};
        check("simul_s_ready", bus.s_ready, 1);
        @(negedge clk);
        bus.cfg_we  = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        wait_mvalid(lat, md);
        check("simul_latency", lat, 10);
        check("simul_slice2", md[5:4], 2'b01);
        check("simul_data", md, 16'hAA9B);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
